// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the arbitrated ALU.
package alu_pkg;

   localparam logic [2:0] OP_SHIFT = 3'b000;
   localparam logic [2:0] OP_ADD   = 3'b100;
   localparam logic [2:0] OP_AND   = 3'b101;
   localparam logic [2:0] OP_OR    = 3'b110;
   localparam logic [2:0] OP_NOT   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu.sv
// Combinational shared ALU: bidirectional logical shift, add, and, or, not.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [2:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_y,
   output logic              o_illegal
);

   logic [DATA_W-1:0] w_amt;
   logic [DATA_W-1:0] w_shift;

   // A negative b shifts right by its magnitude; any distance past the word width clears it.
   always_comb begin
      w_amt   = i_b[DATA_W-1] ? (~i_b + DATA_W'(1)) : i_b;
      w_shift = '0;
      if (w_amt < DATA_W'(DATA_W)) begin
         w_shift = i_b[DATA_W-1] ? (i_a >> w_amt) : (i_a << w_amt);
      end
   end

   always_comb begin
      o_y       = '0;
      o_illegal = 1'b0;
      case (i_op)
         OP_SHIFT: o_y = w_shift;
         OP_ADD:   o_y = i_a + i_b;
         OP_AND:   o_y = i_a & i_b;
         OP_OR:    o_y = i_a | i_b;
         OP_NOT:   o_y = ~i_a;
         default:  o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one operation every three cycles.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [2:0]        op0,
   input  logic [2:0]        op1,
   input  logic [DATA_W-1:0] a0,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] b0,
   input  logic [DATA_W-1:0] b1,
   output logic [1:0]        gnt,
   output logic [1:0]        done,
   output logic [DATA_W-1:0] result,
   output logic              err,
   output logic              busy
);

   state_t            r_state;
   logic              r_ptr;
   logic              r_owner;
   logic [1:0]        r_gnt;
   logic [1:0]        r_done;
   logic [2:0]        r_op_p0;
   logic [DATA_W-1:0] r_a_p0;
   logic [DATA_W-1:0] r_b_p0;
   logic [DATA_W-1:0] r_result_p1;
   logic              r_err_p1;
   logic              w_win;
   logic [DATA_W-1:0] w_alu_y;
   logic              w_alu_illegal;

   // A lone requester always wins; on a tie the pointer decides.
   always_comb begin
      w_win = 1'b0;
      if (req == 2'b10) w_win = 1'b1;
      else if (req == 2'b11) w_win = r_ptr;
   end

   // Stage p0: operands of the winner captured at grant time.
   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && req != 2'b00) begin
         r_op_p0 <= w_win ? op1 : op0;
         r_a_p0  <= w_win ? a1 : a0;
         r_b_p0  <= w_win ? b1 : b0;
      end
   end

   alu #(.DATA_W(DATA_W)) u_alu (
      .i_op      (r_op_p0),
      .i_a       (r_a_p0),
      .i_b       (r_b_p0),
      .o_y       (w_alu_y),
      .o_illegal (w_alu_illegal)
   );

   // Stage p1: ALU result registered in EXEC, presented with done in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= 1'b0;
         r_owner     <= 1'b0;
         r_gnt       <= 2'b00;
         r_done      <= 2'b00;
         r_result_p1 <= '0;
         r_err_p1    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  r_owner <= w_win;
                  r_gnt   <= w_win ? 2'b10 : 2'b01;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_result_p1 <= w_alu_y;
               r_err_p1    <= w_alu_illegal;
               r_done      <= r_owner ? 2'b10 : 2'b01;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               r_done  <= 2'b00;
               r_gnt   <= 2'b00;
               r_ptr   <= ~r_owner;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt    = r_gnt;
   assign done   = r_done;
   assign result = r_result_p1;
   assign err    = r_err_p1;
   assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, corner sequences, random ops vs. a reference model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [2:0]  op0, op1;
   logic [15:0] a0, a1, b0, b1;
   logic [1:0]  gnt, done;
   logic [15:0] result;
   logic        err, busy;

   int   n_chk = 0;
   int   n_err = 0;
   logic m_ptr;

   typedef struct {
      logic [1:0]  req;
      logic [2:0]  op0;
      logic [15:0] a0;
      logic [15:0] b0;
      logic [2:0]  op1;
      logic [15:0] a1;
      logic [15:0] b1;
      logic [1:0]  gnt;
      logic [15:0] res;
      logic        err;
   } vec_t;

   vec_t tbl [12];

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .op0    (op0),
      .op1    (op1),
      .a0     (a0),
      .a1     (a1),
      .b0     (b0),
      .b1     (b1),
      .gnt    (gnt),
      .done   (done),
      .result (result),
      .err    (err),
      .busy   (busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference behaviour written from the opcode rules with plain integer arithmetic.
   function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic e);
      longint av, bv, amt;
      av = longint'(a);
      bv = longint'(b);
      e  = 1'b0;
      r  = 16'h0000;
      case (op)
         3'b000: begin
            if (bv < 32768) begin
               amt = bv;
               if (amt < 16) r = 16'((av * (longint'(1) << amt)) % 65536);
            end else begin
               amt = 65536 - bv;
               if (amt < 16) r = 16'(av / (longint'(1) << amt));
            end
         end
         3'b100:  r = 16'((av + bv) % 65536);
         3'b101:  r = a & b;
         3'b110:  r = a | b;
         3'b111:  r = 16'(65535 - av);
         default: e = 1'b1;
      endcase
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_txn(input vec_t v, input string nm, input bit scramble);
      int n;
      req = v.req;
      op0 = v.op0; a0 = v.a0; b0 = v.b0;
      op1 = v.op1; a1 = v.a1; b1 = v.b1;
      @(posedge clk); @(negedge clk);
      check({nm, " gnt"}, 32'(gnt), 32'(v.gnt));
      check({nm, " busy"}, 32'(busy), 32'd1);
      if (scramble) begin
         req = 2'($urandom);
         op0 = 3'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
         op1 = 3'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      end
      n = 1;
      while (done == 2'b00 && n < 6) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      check({nm, " latency"}, 32'(n), 32'd2);
      check({nm, " done"}, 32'(done), 32'(v.gnt));
      check({nm, " result"}, 32'(result), 32'(v.res));
      check({nm, " err"}, 32'(err), 32'(v.err));
      req = scramble ? 2'b00 : (v.req & ~v.gnt);
      @(posedge clk); @(negedge clk);
      check({nm, " idle"}, {29'd0, busy, gnt}, 32'd0);
      check({nm, " done clr"}, 32'(done), 32'd0);
      check({nm, " result hold"}, 32'(result), 32'(v.res));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      m_ptr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1);
   end

   initial begin
      vec_t v;
      logic w;
      rst = 1'b1; req = 2'b00;
      op0 = 3'b0; a0 = 16'h0; b0 = 16'h0;
      op1 = 3'b0; a1 = 16'h0; b1 = 16'h0;
      m_ptr = 1'b0;

      //               req    op0     a0        b0        op1     a1        b1        gnt    res       err
      tbl[0]  = '{2'b01, 3'b100, 16'h0003, 16'h0004, 3'b000, 16'h0000, 16'h0000, 2'b01, 16'h0007, 1'b0};
      tbl[1]  = '{2'b01, 3'b000, 16'h0001, 16'h0004, 3'b000, 16'h0000, 16'h0000, 2'b01, 16'h0010, 1'b0};
      tbl[2]  = '{2'b10, 3'b000, 16'h0000, 16'h0000, 3'b000, 16'h8000, 16'hFFFE, 2'b10, 16'h2000, 1'b0};
      tbl[3]  = '{2'b10, 3'b000, 16'h0000, 16'h0000, 3'b000, 16'hFFFF, 16'h0010, 2'b10, 16'h0000, 1'b0};
      tbl[4]  = '{2'b01, 3'b010, 16'h1234, 16'h5678, 3'b000, 16'h0000, 16'h0000, 2'b01, 16'h0000, 1'b1};
      tbl[5]  = '{2'b10, 3'b000, 16'h0000, 16'h0000, 3'b101, 16'hF0F0, 16'h3C3C, 2'b10, 16'h3030, 1'b0};
      tbl[6]  = '{2'b11, 3'b110, 16'h0F00, 16'h00F0, 3'b111, 16'h1234, 16'h0000, 2'b01, 16'h0FF0, 1'b0};
      tbl[7]  = '{2'b11, 3'b110, 16'h0F00, 16'h00F0, 3'b111, 16'h1234, 16'h0000, 2'b10, 16'hEDCB, 1'b0};
      tbl[8]  = '{2'b11, 3'b100, 16'hFFFF, 16'h0002, 3'b011, 16'h1111, 16'h2222, 2'b01, 16'h0001, 1'b0};
      tbl[9]  = '{2'b11, 3'b100, 16'hFFFF, 16'h0002, 3'b011, 16'h1111, 16'h2222, 2'b10, 16'h0000, 1'b1};
      tbl[10] = '{2'b01, 3'b000, 16'h1234, 16'h8000, 3'b000, 16'h0000, 16'h0000, 2'b01, 16'h0000, 1'b0};
      tbl[11] = '{2'b10, 3'b000, 16'h0000, 16'h0000, 3'b000, 16'hABCD, 16'h0000, 2'b10, 16'hABCD, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset gnt", 32'(gnt), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset result", 32'(result), 32'd0);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("idle no req busy", 32'(busy), 32'd0);

      for (int i = 0; i < 12; i++) begin
         run_txn(tbl[i], $sformatf("vec%0d", i), 1'b0);
      end
      req = 2'b00;

      // Reset while in EXEC: operation is dropped with no done pulse.
      req = 2'b01; op0 = 3'b100; a0 = 16'h0005; b0 = 16'h0006;
      @(posedge clk); @(negedge clk);
      check("abort busy before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; req = 2'b00;
      check("abort busy", 32'(busy), 32'd0);
      check("abort gnt", 32'(gnt), 32'd0);
      check("abort result", 32'(result), 32'd0);
      check("abort done", 32'(done), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("abort no done %0d", k), {30'd0, done}, 32'd0);
      end
      m_ptr = 1'b0;

      // Both requesters keep asking: owners alternate starting with requester 0.
      for (int k = 0; k < 4; k++) begin
         v = '{2'b11, 3'b100, 16'h0001, 16'h0001, 3'b101, 16'hFF00, 16'h0FF0,
               (k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 16'h0002 : 16'h0F00, 1'b0};
         run_txn(v, $sformatf("rr%0d", k), 1'b0);
      end
      req = 2'b00;

      pulse_reset();
      for (int k = 0; k < 40; k++) begin
         v.req = 2'($urandom_range(1, 3));
         v.op0 = 3'($urandom_range(0, 7));
         v.op1 = 3'($urandom_range(0, 7));
         v.a0  = 16'($urandom);
         v.a1  = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       begin v.b0 = 16'($urandom_range(0, 20)); v.b1 = 16'($urandom_range(0, 20)); end
            1:       begin v.b0 = 16'(0 - $urandom_range(0, 20)); v.b1 = 16'(0 - $urandom_range(0, 20)); end
            default: begin v.b0 = 16'($urandom); v.b1 = 16'($urandom); end
         endcase
         w = (v.req == 2'b10) ? 1'b1 : ((v.req == 2'b11) ? m_ptr : 1'b0);
         v.gnt = w ? 2'b10 : 2'b01;
         if (w) model(v.op1, v.a1, v.b1, v.res, v.err);
         else   model(v.op0, v.a0, v.b0, v.res, v.err);
         m_ptr = ~w;
         run_txn(v, $sformatf("rnd%0d", k), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 req  input  2  per-requester request level; bit n = requester n.
REQ-004 op0, op1  input  3 each  requester opcode; stable while req[n] high.
REQ-005 a0, a1  input  16 each  operand1 per requester; stable while req[n] high.
REQ-006 b0, b1  input  16 each  operand2 per requester; stable while req[n] high.
REQ-007 gnt  output  2  one-hot owner of the shared ALU; zero when idle.
REQ-008 done  output  2  one-cycle pulse to the owner; result valid that cycle.
REQ-009 result  output  16  registered ALU result; held until the next response.
REQ-010 err  output  1  registered; high with done when the opcode was illegal.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, EXEC and RESP, with no other reachable states.
REQ-013 IDLE: no req -> stay; any req -> pick winner, latch op/a/b, set gnt, -> EXEC.
REQ-014 Winner: single req wins; both high -> requester named by priority pointer ptr.
REQ-015 EXEC: register shared ALU output into result, illegal-opcode flag into err -> RESP.
REQ-016 RESP: done[owner]=1 for exactly one cycle; ptr <= ~owner; gnt cleared on RESP->IDLE edge; -> IDLE.
REQ-017 Latency: req sampled in IDLE at edge k -> done high in cycle k+2; one op per 3 cycles max.
REQ-018 Requester SHALL deassert req on edge sampling done; req still high in next IDLE = new request.
REQ-019 req/op/a/b changes outside IDLE SHALL be ignored; latched copies used.
REQ-020 Opcodes: 000 shift, 100 add, 101 and, 110 or, 111 not(a).
REQ-021 Shift: b[15]=0 -> a << b; b[15]=1 -> a >> (-b), logical; shift >=16 gives 0.
REQ-022 Add wraps modulo 2^16; no carry output.
REQ-023 Opcodes 001, 010, 011 illegal -> result 0x0000, err=1; err=0 for legal ops.
REQ-024 Back-to-back simultaneous requests SHALL alternate owners (round-robin via ptr).
REQ-025 A lone requester SHALL be served on every opportunity regardless of ptr.

Reset
REQ-026 rst high at an edge: state IDLE, gnt=0, done=0, err=0, busy=0, result=0x0000, ptr=0.
REQ-027 rst in EXEC or RESP SHALL abort the operation; no done pulse issued for it.
REQ-028 rst dominates all other inputs on the same edge.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants and the FSM state encoding.
REQ-030 Datapath SHALL be one instance of the existing combinational alu module.
REQ-031 Latched op/a/b, ptr, owner, result, err SHALL be flops in alu_arbiter only.

Verification
REQ-032 After rst, req=01, op0=100, a0=0x0003, b0=0x0004 -> done=01 two cycles later, result=0x0007, err=0.
REQ-033 req=11 same cycle (ptr=0), both held -> requester 0 served first, then requester 1; done never 11.
REQ-034 op=000, a=0x0001, b=0x0004 -> 0x0010; a=0x8000, b=0xFFFE -> 0x2000; a=0xFFFF, b=0x0010 -> 0x0000.
REQ-035 op=010, a=0x1234, b=0x5678 -> result=0x0000, err=1 with done; next legal op -> err=0.
REQ-036 rst pulsed while busy=1 in EXEC -> next cycle IDLE, gnt=0, result=0x0000, no done pulse.
REQ-037 Requester 0 holds req high 4 ops while requester 1 requests continuously -> done alternates 01,10,01,10.
